// File: rtl/race_director.sv
// Race sequencer: owns the shared game state bus, runs the 3-2-1 countdown,
// tracks per-player lap progress by map quadrant and declares the winner.
module race_director #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter logic [9:0]  MAP_W       = 10'd320,
  parameter logic [9:0]  MAP_H       = 10'd240,
  parameter logic [7:0]  COUNT_TICKS = 8'd60,
  parameter logic [3:0]  NUM_LAPS    = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [2:0]  state,
  output logic [1:0]  countdown,
  output logic [3:0]  p1_laps,
  output logic [3:0]  p2_laps,
  output logic [1:0]  winner,
  output logic [15:0] race_frames
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT3   = 3'd1,
    S_CNT2   = 3'd2,
    S_CNT1   = 3'd3,
    S_RACE   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam int unsigned TICK_LAST_I = CLK_FREQ / 60;
  localparam int          TICK_W      = (TICK_LAST_I > 0) ? $clog2(TICK_LAST_I + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_LAST_I);
  localparam logic [9:0]  CX        = MAP_W >> 1;
  localparam logic [9:0]  CY        = MAP_H >> 1;
  localparam logic [7:0]  STEP_LAST = COUNT_TICKS - 8'd1;

  state_t            state_q;
  state_t            state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic              game_tick;
  logic              btn_q;
  logic              start_edge;
  logic              start_race;
  logic              race_tick;
  logic              counting;
  logic              step_done;
  logic [7:0]        step_q;

  logic [1:0][9:0]   pos_x;
  logic [1:0][9:0]   pos_y;
  logic [1:0][1:0]   sector;
  logic [1:0][1:0]   last_q;
  logic [1:0]        armed_q;
  logic [1:0]        advance;
  logic [1:0]        lap_wrap;
  logic [1:0]        reach;
  logic [1:0][3:0]   laps_q;
  logic [1:0][3:0]   laps_nxt;
  logic [1:0]        win_nxt;
  logic [1:0]        winner_q;
  logic [15:0]       frames_q;

  // Game tick: one clock in every TICK_LAST+1, first one right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign game_tick = (tick_cnt == '0);

  // Follows the button even in reset so a press held through reset is no edge.
  always_ff @(posedge clk) begin
    btn_q <= start_btn;
  end

  assign start_edge = start_btn & ~btn_q;
  assign start_race = (state_q == S_IDLE) && start_edge;
  assign race_tick  = (state_q == S_RACE) && game_tick;
  assign step_done  = game_tick && (step_q == STEP_LAST);

  assign pos_x = {p2_x, p1_x};
  assign pos_y = {p2_y, p1_y};

  // Per-player quadrant, forward-progress and post-increment lap values.
  always_comb begin
    sector   = '0;
    advance  = '0;
    lap_wrap = '0;
    laps_nxt = laps_q;
    reach    = '0;
    for (int i = 0; i < 2; i++) begin
      case ({pos_y[i] >= CY, pos_x[i] >= CX})
        2'b00:   sector[i] = 2'd0;
        2'b01:   sector[i] = 2'd1;
        2'b11:   sector[i] = 2'd2;
        default: sector[i] = 2'd3;
      endcase
      advance[i]  = race_tick && (sector[i] == last_q[i] + 2'd1);
      lap_wrap[i] = advance[i] && (sector[i] == 2'd0);
      if (lap_wrap[i] && armed_q[i] && (laps_q[i] != 4'hF)) begin
        laps_nxt[i] = laps_q[i] + 4'd1;
      end
      reach[i] = (laps_nxt[i] >= NUM_LAPS);
    end
  end

  // Bit 0 = P1, bit 1 = P2, so a simultaneous finish encodes as a tie (3).
  assign win_nxt = race_tick ? reach : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (start_edge) state_nxt = S_CNT3;
      S_CNT3:   if (step_done)  state_nxt = S_CNT2;
      S_CNT2:   if (step_done)  state_nxt = S_CNT1;
      S_CNT1:   if (step_done)  state_nxt = S_RACE;
      S_RACE:   if (|win_nxt)   state_nxt = S_FINISH;
      S_FINISH: if (start_edge) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    countdown = 2'd0;
    case (state_q)
      S_CNT3:  countdown = 2'd3;
      S_CNT2:  countdown = 2'd2;
      S_CNT1:  countdown = 2'd1;
      default: countdown = 2'd0;
    endcase
  end

  assign counting = (countdown != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || start_race) begin
      step_q <= 8'd0;
    end else if (counting && game_tick) begin
      step_q <= step_done ? 8'd0 : step_q + 8'd1;
    end
  end

  // Race results: cleared only when a new countdown starts, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst || start_race) begin
      last_q   <= '1;
      armed_q  <= '0;
      laps_q   <= '0;
      winner_q <= 2'd0;
      frames_q <= 16'd0;
    end else if (race_tick) begin
      for (int i = 0; i < 2; i++) begin
        if (advance[i]) begin
          last_q[i] <= sector[i];
        end
        if (lap_wrap[i] && !armed_q[i]) begin
          armed_q[i] <= 1'b1;
        end
      end
      laps_q <= laps_nxt;
      if (|win_nxt) begin
        winner_q <= win_nxt;
      end
      if (frames_q != 16'hFFFF) begin
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  assign state       = state_q;
  assign p1_laps     = laps_q[0];
  assign p2_laps     = laps_q[1];
  assign winner      = winner_q;
  assign race_frames = frames_q;

endmodule

// File: tb/tb_race_director.sv
// Bench for race_director: randomized positions checked every cycle against a
// tick-level model that counts forward quadrant steps per player.
module tb_race_director;

  localparam int CLK_FREQ    = 600;
  localparam int PERIOD      = CLK_FREQ / 60 + 1;
  localparam int COUNT_TICKS = 2;
  localparam int NUM_LAPS    = 3;
  localparam int MAP_W       = 320;
  localparam int MAP_H       = 240;
  localparam int CX          = MAP_W / 2;
  localparam int CY          = MAP_H / 2;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        start_btn = 1'b0;
  logic [9:0]  p1_x      = 10'd0;
  logic [9:0]  p1_y      = 10'd0;
  logic [9:0]  p2_x      = 10'd0;
  logic [9:0]  p2_y      = 10'd0;
  logic [2:0]  state;
  logic [1:0]  countdown;
  logic [3:0]  p1_laps;
  logic [3:0]  p2_laps;
  logic [1:0]  winner;
  logic [15:0] race_frames;
  logic [30:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase 0 idle, 1..3 countdown, 4 race, 5 finish.
  int m_div    = 0;
  int m_phase  = 0;
  int m_step   = 0;
  int m_frames = 0;
  int m_win    = 0;
  int m_fwd[2];
  int m_laps[2];
  bit m_btn_prev = 1'b0;
  int cur_sec[2];

  race_director #(
    .CLK_FREQ   (CLK_FREQ),
    .MAP_W      (10'(MAP_W)),
    .MAP_H      (10'(MAP_H)),
    .COUNT_TICKS(8'(COUNT_TICKS)),
    .NUM_LAPS   (4'(NUM_LAPS))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .state      (state),
    .countdown  (countdown),
    .p1_laps    (p1_laps),
    .p2_laps    (p2_laps),
    .winner     (winner),
    .race_frames(race_frames)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, countdown, p1_laps, p2_laps, winner, race_frames};

  function automatic int quadrant(input int x, input int y);
    int below;
    int right;
    below = (y >= CY) ? 1 : 0;
    right = (x >= CX) ? 1 : 0;
    return 2 * below + (right ^ below);
  endfunction

  function automatic logic [30:0] exp_vec();
    logic [1:0] cd;
    cd = (m_phase >= 1 && m_phase <= 3) ? 2'(4 - m_phase) : 2'd0;
    return {3'(m_phase), cd, 4'(m_laps[0]), 4'(m_laps[1]), 2'(m_win), 16'(m_frames)};
  endfunction

  function automatic void model_update();
    bit tick;
    bit edge_s;
    bit r1;
    bit r2;
    int q;
    if (rst) begin
      m_div = 0; m_phase = 0; m_step = 0; m_frames = 0; m_win = 0;
      m_fwd = '{0, 0}; m_laps = '{0, 0};
      m_btn_prev = start_btn;
      return;
    end
    tick   = (m_div == 0);
    edge_s = start_btn && !m_btn_prev;
    m_btn_prev = start_btn;
    m_div = (m_div + 1) % PERIOD;
    case (m_phase)
      0: if (edge_s) begin
        m_phase = 1; m_step = 0; m_frames = 0; m_win = 0;
        m_fwd = '{0, 0}; m_laps = '{0, 0};
      end
      1, 2, 3: if (tick) begin
        m_step++;
        if (m_step == COUNT_TICKS) begin
          m_phase++;
          m_step = 0;
        end
      end
      4: if (tick) begin
        for (int p = 0; p < 2; p++) begin
          q = (p == 0) ? quadrant(int'(p1_x), int'(p1_y)) : quadrant(int'(p2_x), int'(p2_y));
          if (q == (3 + m_fwd[p] + 1) % 4) m_fwd[p]++;
          m_laps[p] = (m_fwd[p] == 0) ? 0 : (((m_fwd[p] - 1) / 4 > 15) ? 15 : (m_fwd[p] - 1) / 4);
        end
        if (m_frames < 65535) m_frames++;
        r1 = (m_laps[0] >= NUM_LAPS);
        r2 = (m_laps[1] >= NUM_LAPS);
        if (r1 || r2) begin
          m_win = (r1 && r2) ? 3 : (r1 ? 1 : 2);
          m_phase = 5;
        end
      end
      5: if (edge_s) m_phase = 0;
      default: m_phase = 0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_pos(input int p, input int sec);
    bit right;
    bit below;
    int x;
    int y;
    right = (sec == 1 || sec == 2);
    below = (sec >= 2);
    if (right) x = ($urandom_range(0, 3) == 0) ? CX : int'($urandom_range(CX, MAP_W - 1));
    else       x = ($urandom_range(0, 3) == 0) ? CX - 1 : int'($urandom_range(0, CX - 1));
    if (below) y = ($urandom_range(0, 3) == 0) ? CY : int'($urandom_range(CY, MAP_H - 1));
    else       y = ($urandom_range(0, 3) == 0) ? CY - 1 : int'($urandom_range(0, CY - 1));
    if (p == 0) begin p1_x = 10'(x); p1_y = 10'(y); end
    else begin p2_x = 10'(x); p2_y = 10'(y); end
    cur_sec[p] = sec;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_btn = 1'b0;
    set_pos(0, 0);
    set_pos(1, 0);
    repeat (3) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL reset: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (state !== 3'd0 || countdown !== 2'd0 || race_frames !== 16'd0 || winner !== 2'd0)
      $display("FAIL reset_values: got state=%0d cd=%0d frames=%0d win=%0d want all 0", state, countdown, race_frames, winner);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_countdown();
    int  n_cnt2;
    int  n_cnt1;
    bit  done;
    n_cnt2 = 0;
    n_cnt1 = 0;
    done = 1'b0;
    start_btn = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      cycle();
      start_btn = 1'b0;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL countdown: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
      else n_pass++;
      if (countdown == 2'd2) n_cnt2++;
      if (countdown == 2'd1) n_cnt1++;
      if (m_phase == 4) done = 1'b1;
    end
    n_checks++;
    if (!done || state !== 3'd4) $display("FAIL countdown_reach_race: got state=%0d want 4", state);
    else n_pass++;
    n_checks++;
    if (n_cnt2 != COUNT_TICKS * PERIOD || n_cnt1 != COUNT_TICKS * PERIOD)
      $display("FAIL countdown_length: got cnt2=%0d cnt1=%0d cycles want %0d each", n_cnt2, n_cnt1, COUNT_TICKS * PERIOD);
    else n_pass++;
  endtask

  task automatic test_laps();
    int seq[6] = '{3, 0, 1, 2, 3, 0};
    foreach (seq[j]) begin
      set_pos(0, seq[j]);
      set_pos(1, 2);
      repeat (PERIOD) begin
        cycle();
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL laps: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
        else n_pass++;
      end
    end
    n_checks++;
    if (p1_laps !== 4'd1 || p2_laps !== 4'd0 || race_frames !== 16'd6 || state !== 3'd4)
      $display("FAIL laps_first: got l1=%0d l2=%0d frames=%0d state=%0d want 1 0 6 4", p1_laps, p2_laps, race_frames, state);
    else n_pass++;
  endtask

  task automatic test_reverse();
    int seq[9] = '{3, 2, 0, 3, 2, 1, 2, 3, 0};
    foreach (seq[j]) begin
      set_pos(0, seq[j]);
      set_pos(1, 3 - (j % 2));
      repeat (PERIOD) begin
        cycle();
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reverse: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
        else n_pass++;
      end
      if (j == 4) begin
        n_checks++;
        if (p1_laps !== 4'd1) $display("FAIL reverse_no_credit: got l1=%0d want 1", p1_laps);
        else n_pass++;
      end
    end
    n_checks++;
    if (p1_laps !== 4'd2 || race_frames !== 16'd15)
      $display("FAIL reverse_then_forward: got l1=%0d frames=%0d want 2 15", p1_laps, race_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid_race();
    bit done;
    done = 1'b0;
    start_btn = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL mid_reset: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
      else n_pass++;
    end
    rst = 1'b0;
    repeat (5) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL held_button: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (state !== 3'd0 || p1_laps !== 4'd0 || race_frames !== 16'd0)
      $display("FAIL held_button_idle: got state=%0d l1=%0d frames=%0d want 0 0 0", state, p1_laps, race_frames);
    else n_pass++;
    start_btn = 1'b0;
    cycle();
    start_btn = 1'b1;
    cycle();
    n_checks++;
    if (state !== 3'd1 || countdown !== 2'd3) $display("FAIL repress_start: got state=%0d cd=%0d want 1 3", state, countdown);
    else n_pass++;
    start_btn = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL restart_countdown: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
      else n_pass++;
      if (m_phase == 4) done = 1'b1;
    end
    n_checks++;
    if (!done || state !== 3'd4) $display("FAIL restart_reach_race: got state=%0d want 4", state);
    else n_pass++;
  endtask

  task automatic test_tie();
    for (int j = 0; j < 13; j++) begin
      set_pos(0, j % 4);
      set_pos(1, j % 4);
      repeat (PERIOD) begin
        cycle();
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL tie: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
        else n_pass++;
      end
    end
    n_checks++;
    if (winner !== 2'd3 || state !== 3'd5 || race_frames !== 16'd13 || p1_laps !== 4'd3 || p2_laps !== 4'd3)
      $display("FAIL tie_result: got win=%0d state=%0d frames=%0d l1=%0d l2=%0d want 3 5 13 3 3",
               winner, state, race_frames, p1_laps, p2_laps);
    else n_pass++;
  endtask

  task automatic test_finish_hold();
    start_btn = 1'b1;
    repeat (3) begin
      cycle();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL finish_hold: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
      else n_pass++;
    end
    start_btn = 1'b0;
    cycle();
    n_checks++;
    if (state !== 3'd0 || winner !== 2'd3 || p1_laps !== 4'd3 || p2_laps !== 4'd3 || race_frames !== 16'd13)
      $display("FAIL finish_results_held: got state=%0d win=%0d l1=%0d l2=%0d frames=%0d want 0 3 3 3 13",
               state, winner, p1_laps, p2_laps, race_frames);
    else n_pass++;
    start_btn = 1'b1;
    cycle();
    n_checks++;
    if (state !== 3'd1 || winner !== 2'd0 || p1_laps !== 4'd0 || p2_laps !== 4'd0 || race_frames !== 16'd0)
      $display("FAIL new_race_clear: got state=%0d win=%0d l1=%0d l2=%0d frames=%0d want 1 0 0 0 0",
               state, winner, p1_laps, p2_laps, race_frames);
    else n_pass++;
    start_btn = 1'b0;
  endtask

  task automatic test_random_races();
    int r;
    int sec;
    for (int race = 0; race < 2; race++) begin
      for (int k = 0; k < 300 && m_phase != 4; k++) begin
        cycle();
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL rand_countdown: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
        else n_pass++;
      end
      for (int w = 0; w < 150 && m_phase == 4; w++) begin
        for (int p = 0; p < 2; p++) begin
          r = int'($urandom_range(0, 9));
          if (r < 6)      sec = (cur_sec[p] + 1) % 4;
          else if (r < 8) sec = cur_sec[p];
          else            sec = int'($urandom_range(0, 3));
          set_pos(p, sec);
        end
        start_btn = ($urandom_range(0, 3) == 0);
        repeat (PERIOD) begin
          cycle();
          n_checks++;
          if (dut_vec !== exp_vec()) $display("FAIL rand_race: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
          else n_pass++;
        end
      end
      start_btn = 1'b0;
      for (int k = 0; k < 4; k++) begin
        start_btn = ~start_btn;
        cycle();
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL rand_restart: got %h want %h (state,cd,l1,l2,win,frames)", dut_vec, exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    cur_sec = '{0, 0};
    m_fwd   = '{0, 0};
    m_laps  = '{0, 0};
    test_reset();
    test_countdown();
    test_laps();
    test_reverse();
    test_reset_mid_race();
    test_tie();
    test_finish_hold();
    test_random_races();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
